// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request / HI-LO result bundle between the pipeline and the unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, X, Y, cancel, input busy, done, HI, LO);
    modport slave  (input start, op, X, Y, cancel, output busy, done, HI, LO);
endinterface

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [CNT_W-1:0]   count_o
);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               is_div_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;

    // acc holds {upper, lower}: product bits shift in from the top for multiply,
    // remainder/quotient for divide (quotient bits enter at bit 0).
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        trial     = rem_shift - {1'b0, b_q};
        acc_d     = acc_q;
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            count_q  <= '0;
        end else if (load_i) begin
            acc_q    <= {{WIDTH{1'b0}}, a_i};
            b_q      <= b_i;
            is_div_q <= is_div_i;
            count_q  <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            count_q  <= count_q + 1'b1;
        end
    end

    assign acc_o   = acc_q;
    assign count_o = count_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit: FSM, sign handling and architectural HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIVZ_LO = {WIDTH{1'b1}}
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    state_e             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, neg_lo_q, neg_hi_q, divz_q;
    logic [WIDTH-1:0]   x_raw_q;
    logic               load, step, op_signed, op_is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [CNT_W-1:0]   count;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign op_signed = (bus.op == MULT) || (bus.op == DIV);
    assign op_is_div = (bus.op == DIV)  || (bus.op == DIVU);
    assign a_mag     = mag(bus.X, op_signed);
    assign b_mag     = mag(bus.Y, op_signed);

    muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (op_is_div),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .acc_o    (acc),
        .count_o  (count)
    );

    assign prod = neg_lo_q ? -acc : acc;
    assign quot = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MULT, MULTU, DIV, DIVU: begin
                            load    = 1'b1;
                            state_d = CALC;
                        end
                        MTHI:    hi_d = bus.X;
                        MTLO:    lo_d = bus.X;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == CNT_W'(ITERS - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (divz_q) begin
                        hi_d = x_raw_q;
                        lo_d = DIVZ_LO;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Result signs: LO follows X^Y for both ops; a divide remainder follows the dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            divz_q   <= 1'b0;
            x_raw_q  <= '0;
        end else if (load) begin
            is_div_q <= op_is_div;
            neg_lo_q <= op_signed & (bus.X[WIDTH-1] ^ bus.Y[WIDTH-1]);
            neg_hi_q <= op_signed & bus.X[WIDTH-1];
            divz_q   <= op_is_div && (bus.Y == '0);
            x_raw_q  <= bus.X;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] hi_m, lo_m;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .DIVZ_LO(32'hFFFFFFFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic (SV division truncates toward zero).
    task automatic model(input op_e o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        longint      sx, sy, p, q, r;
        logic [63:0] ux, uy, pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        eh = 'x;
        el = 'x;
        case (o)
            MULT: begin
                p = sx * sy;
                eh = p[63:32];
                el = p[31:0];
            end
            MULTU: begin
                pu = ux * uy;
                eh = pu[63:32];
                el = pu[31:0];
            end
            DIV: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFFFFFF;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    eh = r[31:0];
                    el = q[31:0];
                end
            end
            DIVU: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFFFFFF;
                end else begin
                    pu = ux / uy; eh = 32'(ux % uy); el = pu[31:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_op(input op_e o, input logic [31:0] x, input logic [31:0] y,
                         input bit inj, input bit with_cancel);
        logic [31:0] eh, el;
        int          cyc;
        bit          done_early;
        model(o, x, y, eh, el);
        bus.start = 1'b1; bus.op = o; bus.X = x; bus.Y = y; bus.cancel = with_cancel;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        bus.X = $urandom; bus.Y = $urandom;
        cyc = 0;
        done_early = 1'b0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            if (bus.done !== 1'b0) done_early = 1'b1;
            if (inj && cyc == 3) begin
                bus.start = 1'b1; bus.op = MTLO; bus.X = 32'hDEADBEEF;
            end else begin
                bus.start = 1'b0;
            end
            cyc++;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("busy_cycles", 32'(cyc), 32'd33);
        check("done_while_busy", {31'd0, done_early}, 32'd0);
        check("done_pulse", {31'd0, bus.done}, 32'd1);
        check("HI", bus.HI, eh);
        check("LO", bus.LO, el);
        hi_m = eh;
        lo_m = el;
        @(posedge clk); #1;
        check("done_width", {31'd0, bus.done}, 32'd0);
        $display("op=%s X=%h Y=%h -> HI=%h LO=%h (model HI=%h LO=%h) cycles=%0d",
                 o.name(), x, y, bus.HI, bus.LO, eh, el, cyc);
    endtask

    initial begin
        bit seen;
        op_e ro;
        logic [31:0] rx, ry;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = MULT; bus.X = '0; bus.Y = '0; bus.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_HI", bus.HI, 32'd0);
        check("rst_LO", bus.LO, 32'd0);
        $display("reset: busy=%b done=%b HI=%h LO=%h", bus.busy, bus.done, bus.HI, bus.LO);
        rst = 1'b0;
        hi_m = '0; lo_m = '0;

        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        do_op(MULT,  32'hFFFFFFFD, 32'd5,        1'b0, 1'b0);
        do_op(MULT,  32'h80000000, 32'h80000000, 1'b0, 1'b0);
        do_op(DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 1'b0);
        do_op(DIVU,  32'd7,        32'd2,        1'b1, 1'b0);
        do_op(DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        do_op(DIVU,  32'h00001234, 32'd0,        1'b0, 1'b0);
        do_op(DIV,   32'hFFFFFF00, 32'd0,        1'b0, 1'b0);

        // mthi / mtlo write on the edge without going busy
        bus.start = 1'b1; bus.op = MTHI; bus.X = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        hi_m = 32'hA5A5A5A5;
        check("mthi_HI", bus.HI, hi_m);
        check("mthi_LO", bus.LO, lo_m);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        check("mthi_done", {31'd0, bus.done}, 32'd0);
        $display("op=MTHI X=a5a5a5a5 -> HI=%h busy=%b done=%b", bus.HI, bus.busy, bus.done);
        bus.start = 1'b1; bus.op = MTLO; bus.X = 32'h3C3C0F0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lo_m = 32'h3C3C0F0F;
        check("mtlo_LO", bus.LO, lo_m);
        check("mtlo_HI", bus.HI, hi_m);
        $display("op=MTLO X=3c3c0f0f -> LO=%h", bus.LO);

        // undefined op code is ignored
        bus.start = 1'b1; bus.op = op_e'(3'd7); bus.X = 32'h11111111;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("undef_busy", {31'd0, bus.busy}, 32'd0);
        check("undef_HI", bus.HI, hi_m);
        check("undef_LO", bus.LO, lo_m);
        $display("op=7 (undefined) -> busy=%b HI=%h LO=%h", bus.busy, bus.HI, bus.LO);

        // cancel while counter=10
        bus.start = 1'b1; bus.op = MULT; bus.X = 32'h12345678; bus.Y = 32'h9ABCDEF0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        check("cancel_busy", {31'd0, bus.busy}, 32'd0);
        check("cancel_done", {31'd0, bus.done}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        check("cancel_no_done", {31'd0, seen}, 32'd0);
        check("cancel_HI", bus.HI, hi_m);
        check("cancel_LO", bus.LO, lo_m);
        $display("op=MULT cancelled at count 10 -> busy=%b HI=%h LO=%h", bus.busy, bus.HI, bus.LO);

        // asynchronous reset mid-calculation
        bus.start = 1'b1; bus.op = DIVU; bus.X = 32'hCAFEF00D; bus.Y = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_HI", bus.HI, 32'd0);
        check("arst_LO", bus.LO, 32'd0);
        $display("async reset mid-CALC -> busy=%b HI=%h LO=%h", bus.busy, bus.HI, bus.LO);
        #2;
        rst = 1'b0;
        hi_m = '0; lo_m = '0;
        @(posedge clk); #1;
        check("arst_stays_idle", {31'd0, bus.busy}, 32'd0);

        // random operations, occasional zero divisor
        for (int i = 0; i < 12; i++) begin
            ro = op_e'($urandom_range(0, 3));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(0, 31);
            do_op(ro, rx, ry, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide responder with architectural HI/LO registers for the MIPS core. It replaces the single-cycle combinational multiply and divide paths. It accepts an operation from the execute stage when idle, iterates one bit per cycle, and returns a 64-bit product or a quotient/remainder into HI/LO with a done pulse. The pipeline stalls on busy and reads HI/LO directly for mfhi/mflo.

Parameters:
WIDTH, 32, operand width; the unit is verified only at 32.
DIVZ_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  request strobe; sampled only when busy=0.
op  input  3  operation code (package enum): MULT, MULTU, DIV, DIVU, MTHI, MTLO.
X  input  WIDTH  operand A: multiplicand, dividend, or mthi/mtlo data.
Y  input  WIDTH  operand B: multiplier or divisor.
cancel  input  1  exception flush; aborts an in-flight operation.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when HI/LO take a mul/div result.
HI  output  WIDTH  HI register: product[63:32] or remainder.
LO  output  WIDTH  LO register: product[31:0] or quotient.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0. Reset takes effect immediately, including mid-operation.
- States:
  - IDLE: accepts work. start with MULT/MULTU/DIV/DIVU goes to CALC. Operands are latched as magnitudes; for signed ops the result signs are recorded. busy=1 from that edge.
  - IDLE with MTHI/MTLO: start writes X into HI or LO at that edge. State stays IDLE; busy and done stay 0.
  - CALC: 32 iterations, counter 0..31, one per cycle. Multiply is shift-add on a 64-bit accumulator. Divide is restoring: shift remainder left, trial-subtract the divisor magnitude, set the quotient bit.
  - CALC, counter=31: go to FIX.
  - FIX: one cycle. Apply sign correction and write HI/LO. Assert done for exactly one cycle, then return to IDLE; busy drops at the same edge.
- Latency: start sampled at edge 0; HI/LO updated and done=1 after edge 33; busy high for 33 cycles. A new start is accepted in the cycle done=1.
- start while busy=1 is ignored, with no queueing. Undefined op codes are ignored.
- cancel=1 in CALC or FIX: return to IDLE at the next edge. busy=0, no done, HI/LO unchanged. cancel in IDLE has no effect; if start and cancel are both high in IDLE, start wins.
- Signed rules:
  - Product sign = X[31]^Y[31].
  - Quotient sign = X[31]^Y[31]; remainder sign = X[31] (truncating division, MIPS semantics).
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Divide-by-zero (Y=0, DIV or DIVU): still takes the full 33 cycles. LO=DIVZ_LO, HI=X (raw dividend). done pulses normally.
- No overflow or carry flags: HI/LO hold the full 64-bit result.

Decomposition:
- Shared package muldiv_pkg:
  - op enum (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5).
  - State enum (IDLE, CALC, FIX).
  - Iteration count constant (32).
- Natural sub-module: muldiv_iter. It is the per-cycle shift/add/subtract datapath holding the accumulator, divisor, and counter, with a step/load interface. muldiv_unit keeps the FSM, sign handling, and HI/LO.

Test Plan:
- MULTU X=0xFFFFFFFF Y=0xFFFFFFFF -> done one cycle after edge 33, HI=0xFFFFFFFE, LO=0x00000001; busy=1 for exactly 33 cycles.
- MULT X=0xFFFFFFFD (-3) Y=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Also MULT X=0x80000000 Y=0x80000000 -> HI=0x40000000, LO=0.
- DIV X=0xFFFFFFF9 (-7) Y=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU X=7 Y=2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU X=0x1234 Y=0 -> LO=0xFFFFFFFF, HI=0x1234, done pulses.
- MTHI X=0xA5A5A5A5 when idle -> HI=0xA5A5A5A5 next edge with busy=0, done=0. MTLO or any start issued while busy is ignored: HI/LO reflect only the in-flight op.
- cancel at CALC counter=10 -> busy=0 next edge, no done, HI/LO keep prior values. Separately, rst pulsed mid-CALC -> HI=LO=0, busy=done=0 immediately, without waiting for a clock edge.
